// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter FIFO.
//   master : drives wr / wdata / clr_ovf and observes the FIFO status
//   slave  : the transmitter; accepts bytes and reports full / empty / level / ovf
// FIFO_DEPTH must match the FIFO_DEPTH of the uart_tx_fifo instance,
// because it sets the width of level.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr;       // push strobe
    logic [7:0]       wdata;    // byte to push
    logic             clr_ovf;  // clear sticky overflow
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic             ovf;      // sticky: a write was dropped

    modport master (output wr, wdata, clr_ovf, input full, empty, level, ovf);
    modport slave  (input wr, wdata, clr_ovf, output full, empty, level, ovf);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   en            : allows new frames to start; a running frame always completes
//   prescale      : bit period minus one, in HCLK cycles, latched at each frame start
//   bus (slave)   : FIFO write port and status (wr, wdata, clr_ovf, full, empty, level, ovf)
//   tx            : serial output, idle high
//   busy          : a frame is on the line
//   done          : high for the last cycle of each stop bit
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    uart_tx_fifo_if.slave         bus,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full_w, empty_w, ovf_q;
    logic          push, pop, drop;

    assign full_w  = (count == FULL_CNT);
    assign empty_w = (count == '0);
    // full is the registered occupancy, so a write against a full FIFO is
    // dropped even if the transmitter pops on the same edge.
    assign push    = bus.wr && !full_w;
    assign drop    = bus.wr &&  full_w;

    // Storage has no reset; discarding contents is done by clearing pointers.
    always_ff @(posedge HCLK) begin
        if (push) mem[wptr] <= bus.wdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            // A drop on the same edge as clr_ovf keeps the flag set.
            if (drop)             ovf_q <= 1'b1;
            else if (bus.clr_ovf) ovf_q <= 1'b0;
        end
    end

    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.level = count;
    assign bus.ovf   = ovf_q;

    // ----------------------------------------------------------- transmitter
    state_t                state, state_d;
    logic [7:0]            shreg, shreg_d;
    logic [2:0]            bit_cnt, bit_cnt_d;
    logic [PRESCALE_W-1:0] baud, baud_d, presc, presc_d;
    logic                  tx_q, tx_d;
    logic                  bit_end, can_start, start_frame;

    assign bit_end   = (baud == presc);
    assign can_start = en && !empty_w;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            presc   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            baud    <= baud_d;
            presc   <= presc_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d     = state;
        shreg_d     = shreg;
        bit_cnt_d   = bit_cnt;
        baud_d      = baud;
        presc_d     = presc;
        tx_d        = tx_q;
        start_frame = 1'b0;

        if (state != IDLE) baud_d = bit_end ? '0 : baud + PRESCALE_W'(1);

        case (state)
            IDLE:  if (can_start) start_frame = 1'b1;
            START: if (bit_end) begin
                state_d = DATA;
                tx_d    = shreg[0];
            end
            DATA:  if (bit_end) begin
                if (bit_cnt == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt + 3'd1;
                    shreg_d   = shreg >> 1;
                    tx_d      = shreg[1];   // next bit, LSB first
                end
            end
            STOP:  if (bit_end) begin
                // Chain straight into the next frame when data is waiting.
                if (can_start) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d   = START;
            shreg_d   = mem[rptr];
            tx_d      = 1'b0;
            bit_cnt_d = '0;
            baud_d    = '0;
            presc_d   = prescale;
        end
    end

    assign pop  = start_frame;
    assign tx   = tx_q;
    assign busy = (state != IDLE);
    assign done = (state == STOP) && bit_end;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] prescale = 16'd0;
    logic        tx, busy, done;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .PRESCALE_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescale(prescale),
        .bus(bus), .tx(tx), .busy(busy), .done(done)
    );

    always #5 HCLK = ~HCLK;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];     // scoreboard: bytes expected on the line, in order
    bit         mon_on = 1'b1;
    int         mon_p  = 16;  // bit period the line monitor assumes

    typedef struct {
        logic       wr;
        logic       clr;
        logic [7:0] d;
        logic       accept;   // byte should enter the FIFO and later be sent
        logic [4:0] lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;
    vec_t vt[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit expect_tx);
        bus.wr    = 1'b1;
        bus.wdata = d;
        tick();
        bus.wr    = 1'b0;
        if (expect_tx) exp_q.push_back(d);
    endtask

    // Called just after the frame-start edge; walks the whole frame cycle by cycle.
    task automatic frame_check(input string name, input logic [7:0] d, input int p);
        int         bad = 0;
        int         n_done = 0;
        int         done_at = -1;
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int c = 1; c <= 10*p; c++) begin
            if (tx !== bits[(c-1)/p]) bad++;
            if (busy !== 1'b1) bad++;
            if (done === 1'b1) begin
                n_done++;
                done_at = c;
            end
            tick();
        end
        check({name, "_tx_pattern"}, bad, 0);
        check({name, "_done_cycle"}, done_at, 10*p);
        check({name, "_done_count"}, n_done, 1);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < maxc) begin
            tick();
            n++;
        end
        check({name, "_drained"}, (exp_q.size() == 0 && busy === 1'b0), 1);
    endtask

    // Line monitor: samples mid-bit on the falling clock edge and checks each
    // decoded byte against the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge HCLK);
            if (mon_on && HRESETn && tx === 1'b0) begin
                repeat (mon_p/2) @(negedge HCLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_p) @(negedge HCLK);
                    b[i] = tx;
                end
                repeat (mon_p) @(negedge HCLK);
                stp = tx;
                check("rx_stop_bit", stp, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %02h, no byte expected", b);
                end else begin
                    check("rx_byte", b, exp_q.pop_front());
                end
                $display("uart rx: %02h '%c'", b, b);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int busy_lo, n_done, bad;

        for (int i = 0; i < 20; i++) begin
            vt[i] = '{wr: 1'b0, clr: 1'b0, d: 8'h00, accept: 1'b0,
                      lvl: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0};
            if (i < 16) begin
                vt[i].wr     = 1'b1;
                vt[i].d      = 8'h30 + 8'(i);
                vt[i].accept = 1'b1;
                vt[i].lvl    = 5'(i + 1);
                vt[i].full   = (i == 15);
            end
        end
        vt[16].wr = 1'b1; vt[16].d = 8'hAA; vt[16].ovf = 1'b1;   // 17th write dropped
        vt[17].clr = 1'b1;                                        // clear
        vt[18].wr = 1'b1; vt[18].clr = 1'b1; vt[18].d = 8'hBB;    // drop + clear: set wins
        vt[18].ovf = 1'b1;
        vt[19].clr = 1'b1;

        bus.wr = 1'b0; bus.wdata = 8'h00; bus.clr_ovf = 1'b0;

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_tx",    tx, 1);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_level", bus.level, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full",  bus.full, 0);
        check("rst_ovf",   bus.ovf, 0);
        HRESETn = 1'b1;
        tick();

        // Single 'A' at prescale 15; prescale changed mid-frame must not matter
        prescale = 16'd15; en = 1'b1; mon_p = 16;
        tick();
        wr_byte(8'h41, 1'b1);
        check("a_latency_tx_still_idle", tx, 1);
        check("a_level_after_write", bus.level, 1);
        tick();
        prescale = 16'd7;
        frame_check("a", 8'h41, 16);
        check("a_idle_after", {busy, tx}, 2'b01);
        wait_drain("a", 50);

        // prescale 0: 0xFF then 0x00, 10-cycle frames back to back
        prescale = 16'd0; mon_p = 1;
        tick();
        wr_byte(8'hFF, 1'b1);
        wr_byte(8'h00, 1'b1);
        check("b_level_push_pop", bus.level, 1);
        frame_check("b_ff", 8'hFF, 1);
        frame_check("b_00", 8'h00, 1);
        check("b_idle_after", {busy, tx}, 2'b01);
        wait_drain("b", 50);

        // "Hi\n" back to back at prescale 15: 480 busy cycles, three done pulses
        prescale = 16'd15; mon_p = 16;
        tick();
        wr_byte(8'h48, 1'b1);
        wr_byte(8'h69, 1'b1);
        wr_byte(8'h0A, 1'b1);
        busy_lo = 0; n_done = 0;
        for (int c = 2; c <= 480; c++) begin
            if (busy !== 1'b1) busy_lo++;
            if (done === 1'b1) n_done++;
            tick();
        end
        check("hi_busy_gaps", busy_lo, 0);
        check("hi_done_count", n_done, 3);
        check("hi_idle_at_481", {busy, tx, bus.empty}, 3'b011);
        wait_drain("hi", 50);

        // Table: fill with en=0, overflow, clr_ovf, set-wins
        en = 1'b0; prescale = 16'd3; mon_p = 4;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.wr = vt[i].wr; bus.wdata = vt[i].d; bus.clr_ovf = vt[i].clr;
            tick();
            if (vt[i].accept) exp_q.push_back(vt[i].d);
            check($sformatf("vec%0d_level", i), bus.level, vt[i].lvl);
            check($sformatf("vec%0d_full_empty_ovf_busy", i),
                  {bus.full, bus.empty, bus.ovf, busy},
                  {vt[i].full, vt[i].empty, vt[i].ovf, 1'b0});
        end
        bus.wr = 1'b0; bus.clr_ovf = 1'b0;

        // Write while full with a pop on the same edge: dropped
        en = 1'b1; bus.wr = 1'b1; bus.wdata = 8'hEE;
        tick();
        bus.wr = 1'b0;
        check("full_pop_level", bus.level, DEPTH - 1);
        check("full_pop_ovf", bus.ovf, 1);
        check("full_pop_busy", busy, 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("full_pop_clr_ovf", bus.ovf, 0);
        wait_drain("table", 1000);

        // Asynchronous reset mid-DATA with 5 bytes queued
        mon_on = 1'b0; prescale = 16'd15;
        tick();
        for (int i = 0; i < 6; i++) wr_byte(8'h50 + 8'(i), 1'b0);
        check("rst_mid_level_before", bus.level, 5);
        repeat (30) tick();
        check("rst_mid_busy_before", busy, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("rst_mid_async", {tx, busy, bus.level, bus.empty}, {1'b1, 1'b0, 5'd0, 1'b1});
        #2;
        HRESETn = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("rst_mid_no_frame_after", bad, 0);
        check("rst_mid_level_after", bus.level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
